// File: rtl/shift_pkg.sv
// Shared encodings for the shift sequencer: bank select codes, FSM states
// and the per-bit 4:1 select cell used by the register bank.
package shift_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_UP   = 2'b10;
    localparam logic [1:0] SEL_DOWN = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic sel_cell(input logic [1:0] sel, input logic hold_v,
                                      input logic load_v, input logic up_v,
                                      input logic down_v);
        logic r;
        unique case (sel)
            SEL_HOLD: r = hold_v;
            SEL_LOAD: r = load_v;
            SEL_UP:   r = up_v;
            default:  r = down_v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: one 4:1 select cell per bit choosing
// hold, parallel load, shift up (from ser_in_r) or shift down (from ser_in_l).
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       select,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] up_in;
    logic [WIDTH-1:0] down_in;

    // Neighbour taps: shift up pulls from the bit below, shift down from the bit above.
    assign up_in   = {q_q[WIDTH-2:0], ser_in_r};
    assign down_in = {ser_in_l, q_q[WIDTH-1:1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign q_d[i] = sel_cell(select, q_q[i], par_in[i], up_in[i], down_in[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for the universal shift register: loads a word, issues the
// requested number of shifts (honouring stall) and pulses done on completion.
//
// state | meaning
// IDLE  | waiting for a command; loads par_in on accept
// SHIFT | issuing shifts until the latched count reaches zero
// DONE  | one-cycle completion pulse, no command accepted
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             dir,
    input  logic [CNT_W-1:0] length,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic             stall,
    output logic [1:0]       select,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic             dir_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        dir_q   <= dir;
                        count_q <= length;
                        state_q <= (length != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    if (!stall) begin
                        count_q <= count_q - 1'b1;
                        if (count_q == CNT_W'(1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        select = SEL_HOLD;
        unique case (state_q)
            IDLE:    select = start_valid ? SEL_LOAD : SEL_HOLD;
            SHIFT:   select = stall ? SEL_HOLD : (dir_q ? SEL_DOWN : SEL_UP);
            default: select = SEL_HOLD;
        endcase
    end

    univ_shift_reg #(.WIDTH(WIDTH)) u_reg (
        .clk      (clk),
        .rst      (rst),
        .select   (select),
        .par_in   (par_in),
        .ser_in_r (ser_in_r),
        .ser_in_l (ser_in_l),
        .q        (q)
    );

    // Ready is masked during reset so no command is taken on a reset edge.
    assign start_ready   = (state_q == IDLE) && !rst;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign ser_out_valid = (state_q == SHIFT) && !stall;
    assign ser_out       = dir_q ? q[0] : q[WIDTH-1];

endmodule
